// File: rtl/imem_loadable_if.sv
// Load-channel and fetch-port bundle for imem_loadable.
// The master side is the boot loader / fetch stage; the slave side is the memory.
interface imem_loadable_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_count;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_busy;
    logic              load_done;
    logic              fetch_en;
    logic [ADDR_W+1:0] fetch_pc;
    logic              fetch_stall;
    logic              fetch_flush;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_valid;
    logic              fetch_misalign;

    modport master (
        output load_start, load_base, load_count, load_valid, load_data,
        output fetch_en, fetch_pc, fetch_stall, fetch_flush,
        input  load_ready, load_busy, load_done,
        input  fetch_instr, fetch_valid, fetch_misalign
    );

    modport slave (
        input  load_start, load_base, load_count, load_valid, load_data,
        input  fetch_en, fetch_pc, fetch_stall, fetch_flush,
        output load_ready, load_busy, load_done,
        output fetch_instr, fetch_valid, fetch_misalign
    );
endinterface

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: burst-filled over a valid/ready channel,
// then serves byte-addressed fetches with one cycle of latency.
module imem_loadable #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 10,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_loadable_if.slave bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [ADDR_W:0] ONE_LEFT = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_en;
    logic              accept;
    logic [ADDR_W-1:0] rd_idx;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign accept = (state_q == LOAD) && bus.load_valid;
    assign rd_idx = bus.fetch_pc[ADDR_W+1:2];

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        if (state_q == LOAD) begin
            if (accept) begin
                wptr_d   = wptr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                if (remain_q == ONE_LEFT) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
        end else if (bus.load_start && (bus.load_count != '0)) begin
            state_d  = LOAD;
            wptr_d   = bus.load_base;
            remain_d = bus.load_count;
        end
    end

    // Flush beats stall; stall freezes both the flags and the read register.
    always_comb begin
        valid_d    = valid_q;
        misalign_d = misalign_q;
        rd_en      = 1'b0;
        if (bus.fetch_flush) begin
            valid_d    = 1'b0;
            misalign_d = 1'b0;
        end else if (!bus.fetch_stall) begin
            valid_d    = 1'b0;
            misalign_d = 1'b0;
            if ((state_q == RUN) && bus.fetch_en) begin
                if (bus.fetch_pc[1:0] == 2'b00) begin
                    valid_d = 1'b1;
                    rd_en   = 1'b1;
                end else begin
                    misalign_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            wptr_q     <= '0;
            remain_q   <= '0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            remain_q   <= remain_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Reset-free so the array and read register map onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr_q] <= bus.load_data;
        end
        if (rd_en) begin
            rdata_q <= mem[rd_idx];
        end
    end

    assign bus.load_ready     = (state_q == LOAD);
    assign bus.load_busy      = (state_q == LOAD);
    assign bus.load_done      = done_q;
    assign bus.fetch_valid    = valid_q;
    assign bus.fetch_misalign = misalign_q;
    assign bus.fetch_instr    = valid_q ? rdata_q : NOP_WORD;
endmodule

// File: tb/tb_imem_loadable.sv
// Scenario bench for imem_loadable: a reference model pushes expected fetch
// results into a queue, each scenario pops and compares after the DUT responds.
module tb_imem_loadable;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic        v;
        logic        m;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    imem_loadable_if #(.DATA_W(32), .ADDR_W(10)) bus ();

    imem_loadable #(.DATA_W(32), .ADDR_W(10), .NOP_WORD(32'h00000013)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb [$];
    exp_t        prev;
    exp_t        e;
    logic        model_run;
    logic [31:0] model_mem [1024];
    logic [31:0] ld_words [4];

    // Drive one fetch cycle and queue the result the spec calls for.
    task automatic drive_fetch(input logic en, input logic [11:0] pc, input logic st, input logic fl);
        exp_t x;
        bus.fetch_en    = en;
        bus.fetch_pc    = pc;
        bus.fetch_stall = st;
        bus.fetch_flush = fl;
        if (fl)                      x = '{instr: NOP, v: 1'b0, m: 1'b0};
        else if (st)                 x = prev;
        else if (!model_run || !en)  x = '{instr: NOP, v: 1'b0, m: 1'b0};
        else if (pc[1:0] != 2'b00)   x = '{instr: NOP, v: 1'b0, m: 1'b1};
        else                         x = '{instr: model_mem[pc[11:2]], v: 1'b1, m: 1'b0};
        prev = x;
        sb.push_back(x);
        @(posedge clk); #1;
        bus.fetch_stall = 1'b0;
        bus.fetch_flush = 1'b0;
    endtask

    // Runs a burst from ld_words; reports how many load_done pulses were seen
    // and how many cycles after the last accept the first one appeared.
    task automatic do_load(input logic [9:0] base, input int cnt, output int pulses, output int lat);
        int waited;
        pulses = 0;
        lat    = 0;
        bus.fetch_en   = 1'b0;
        bus.load_base  = base;
        bus.load_count = 11'(cnt);
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = ld_words[k];
            waited = 0;
            while (!bus.load_ready && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!bus.load_ready) begin
                n_tests++;
                n_fail++;
                $display("FAIL load_ready_timeout word=%0d ready=%b required=1", k, bus.load_ready);
                break;
            end
            @(posedge clk); #1;
            model_mem[base + 10'(k)] = ld_words[k];
            if (bus.load_done) begin
                pulses++;
                if (k == cnt - 1 && lat == 0) lat = 1;
            end
        end
        bus.load_valid = 1'b0;
        for (int j = 2; j <= 3; j++) begin
            @(posedge clk); #1;
            if (bus.load_done) begin
                pulses++;
                if (lat == 0) lat = j;
            end
        end
        model_run = 1'b1;
        prev = '{instr: NOP, v: 1'b0, m: 1'b0};
        $display("[TB] load base=%0d count=%0d done_pulses=%0d done_latency=%0d", base, cnt, pulses, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.fetch_instr !== NOP || bus.fetch_valid !== 1'b0 || bus.fetch_misalign !== 1'b0 ||
            bus.load_ready !== 1'b0 || bus.load_busy !== 1'b0 || bus.load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state instr=%h v=%b m=%b rdy=%b busy=%b done=%b required instr=%h others 0",
                     bus.fetch_instr, bus.fetch_valid, bus.fetch_misalign, bus.load_ready, bus.load_busy, bus.load_done, NOP);
        end else $display("[TB] reset_state ok");
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            drive_fetch(1'b1, 12'd0, 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bus.fetch_instr !== e.instr || bus.fetch_valid !== e.v || bus.fetch_misalign !== e.m) begin
                n_fail++;
                $display("FAIL empty_fetch[%0d] got %h/%b/%b required %h/%b/%b", i,
                         bus.fetch_instr, bus.fetch_valid, bus.fetch_misalign, e.instr, e.v, e.m);
            end else $display("[TB] empty_fetch[%0d] instr=%h valid=%b", i, bus.fetch_instr, bus.fetch_valid);
        end
    endtask

    task automatic test_load_basic();
        int pulses, lat;
        ld_words = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233};
        do_load(10'd0, 4, pulses, lat);
        n_tests++;
        if (pulses !== 1 || lat !== 1) begin
            n_fail++;
            $display("FAIL load_done_pulse pulses=%0d latency=%0d required pulses=1 latency=1", pulses, lat);
        end else $display("[TB] load_done_pulse ok");
    endtask

    task automatic test_back_to_back();
        logic [11:0] pcs [6];
        logic        ens [6];
        pcs = '{12'd0, 12'd4, 12'd8, 12'd12, 12'd4, 12'd0};
        ens = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive_fetch(ens[i], pcs[i], 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bus.fetch_instr !== e.instr || bus.fetch_valid !== e.v || bus.fetch_misalign !== e.m) begin
                n_fail++;
                $display("FAIL b2b[%0d] pc=%0d got %h/%b/%b required %h/%b/%b", i, pcs[i],
                         bus.fetch_instr, bus.fetch_valid, bus.fetch_misalign, e.instr, e.v, e.m);
            end else $display("[TB] b2b[%0d] pc=%0d instr=%h valid=%b", i, pcs[i], bus.fetch_instr, bus.fetch_valid);
        end
    endtask

    task automatic test_wrap_load();
        int pulses, lat;
        logic [11:0] pcs [4];
        pcs = '{12'd4088, 12'd4092, 12'd0, 12'd4};
        ld_words = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        do_load(10'd1022, 4, pulses, lat);
        n_tests++;
        if (pulses !== 1 || lat !== 1) begin
            n_fail++;
            $display("FAIL wrap_done pulses=%0d latency=%0d required 1/1", pulses, lat);
        end else $display("[TB] wrap_done ok");
        for (int i = 0; i < 4; i++) begin
            drive_fetch(1'b1, pcs[i], 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bus.fetch_instr !== e.instr || bus.fetch_valid !== e.v || bus.fetch_misalign !== e.m) begin
                n_fail++;
                $display("FAIL wrap_fetch pc=%0d got %h/%b/%b required %h/%b/%b", pcs[i],
                         bus.fetch_instr, bus.fetch_valid, bus.fetch_misalign, e.instr, e.v, e.m);
            end else $display("[TB] wrap_fetch pc=%0d instr=%h", pcs[i], bus.fetch_instr);
        end
    endtask

    task automatic test_misalign();
        logic [11:0] pcs [4];
        pcs = '{12'd6, 12'd1, 12'd8, 12'd3};
        for (int i = 0; i < 4; i++) begin
            drive_fetch(1'b1, pcs[i], 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bus.fetch_instr !== e.instr || bus.fetch_valid !== e.v || bus.fetch_misalign !== e.m) begin
                n_fail++;
                $display("FAIL misalign pc=%0d got %h/%b/%b required %h/%b/%b", pcs[i],
                         bus.fetch_instr, bus.fetch_valid, bus.fetch_misalign, e.instr, e.v, e.m);
            end else $display("[TB] misalign pc=%0d mis=%b valid=%b", pcs[i], bus.fetch_misalign, bus.fetch_valid);
        end
    endtask

    task automatic test_stall_flush();
        logic [11:0] pcs [7];
        logic        sts [7];
        logic        fls [7];
        pcs = '{12'd8, 12'd12, 12'd12, 12'd12, 12'd12, 12'd12, 12'd8};
        sts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fls = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive_fetch(1'b1, pcs[i], sts[i], fls[i]);
            e = sb.pop_front();
            n_tests++;
            if (bus.fetch_instr !== e.instr || bus.fetch_valid !== e.v || bus.fetch_misalign !== e.m) begin
                n_fail++;
                $display("FAIL stall_flush[%0d] st=%b fl=%b got %h/%b/%b required %h/%b/%b", i, sts[i], fls[i],
                         bus.fetch_instr, bus.fetch_valid, bus.fetch_misalign, e.instr, e.v, e.m);
            end else $display("[TB] stall_flush[%0d] st=%b fl=%b instr=%h valid=%b", i, sts[i], fls[i],
                              bus.fetch_instr, bus.fetch_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        int pulses, lat;
        bus.fetch_en   = 1'b0;
        bus.load_base  = 10'd0;
        bus.load_count = 11'd4;
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hE0E00000 + 32'(k);
            @(posedge clk); #1;
            model_mem[k] = 32'hE0E00000 + 32'(k);
        end
        bus.load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_run = 1'b0;
        prev = '{instr: NOP, v: 1'b0, m: 1'b0};
        n_tests++;
        if (bus.fetch_instr !== NOP || bus.fetch_valid !== 1'b0 || bus.load_busy !== 1'b0 || bus.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_load_reset instr=%h v=%b busy=%b rdy=%b required %h/0/0/0",
                     bus.fetch_instr, bus.fetch_valid, bus.load_busy, bus.load_ready, NOP);
        end else $display("[TB] mid_load_reset ok");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            drive_fetch(1'b1, 12'(i * 4), 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bus.fetch_instr !== e.instr || bus.fetch_valid !== e.v || bus.fetch_misalign !== e.m) begin
                n_fail++;
                $display("FAIL post_reset_fetch[%0d] got %h/%b/%b required %h/%b/%b", i,
                         bus.fetch_instr, bus.fetch_valid, bus.fetch_misalign, e.instr, e.v, e.m);
            end else $display("[TB] post_reset_fetch[%0d] instr=%h valid=%b", i, bus.fetch_instr, bus.fetch_valid);
        end
        bus.load_count = 11'd0;
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        n_tests++;
        if (bus.load_busy !== 1'b0 || bus.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_count_start busy=%b rdy=%b required 0/0", bus.load_busy, bus.load_ready);
        end else $display("[TB] zero_count_start ignored");
        drive_fetch(1'b1, 12'd0, 1'b0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (bus.fetch_instr !== e.instr || bus.fetch_valid !== e.v) begin
            n_fail++;
            $display("FAIL zero_count_fetch got %h/%b required %h/%b", bus.fetch_instr, bus.fetch_valid, e.instr, e.v);
        end else $display("[TB] zero_count_fetch instr=%h valid=%b", bus.fetch_instr, bus.fetch_valid);
        ld_words = '{32'h11110000, 32'h22220000, 32'h33330000, 32'h44440000};
        do_load(10'd0, 4, pulses, lat);
        drive_fetch(1'b1, 12'd4, 1'b0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (pulses !== 1 || bus.fetch_instr !== e.instr || bus.fetch_valid !== e.v) begin
            n_fail++;
            $display("FAIL reload_fetch pulses=%0d got %h/%b required 1 %h/%b", pulses,
                     bus.fetch_instr, bus.fetch_valid, e.instr, e.v);
        end else $display("[TB] reload_fetch instr=%h valid=%b", bus.fetch_instr, bus.fetch_valid);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_run = 1'b0;
        prev = '{instr: NOP, v: 1'b0, m: 1'b0};
        rst_n = 1'b0;
        bus.load_start  = 1'b0;
        bus.load_base   = '0;
        bus.load_count  = '0;
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus.fetch_en    = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_stall = 1'b0;
        bus.fetch_flush = 1'b0;
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_wrap_load();
        test_misalign();
        test_stall_flush();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, software-loadable instruction memory; successor to the fixed, self-initialised instruction ROM.
- Filled at run time through a valid/ready load channel, then serves the fetch stage with 1-cycle synchronous reads.
- Adds byte-addressed fetch, stall, flush, misalignment flagging and a NOP guard until a program is loaded.
- Sits between the testbench/boot loader and the IF stage of the pipeline.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 10, word-address width; depth = 2**ADDR_W words.
- NOP_WORD, 32'h00000013, word driven whenever no valid instruction is presented (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a load burst.
- load_base  in  ADDR_W  first word address of the burst; sampled with load_start.
- load_count  in  ADDR_W+1  number of words in the burst; sampled with load_start.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  block accepts a load word this cycle.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse after the last word is written.
- fetch_en  in  1  fetch request.
- fetch_pc  in  ADDR_W+2  byte address; word index = fetch_pc[ADDR_W+1:2].
- fetch_stall  in  1  hold fetch outputs.
- fetch_flush  in  1  kill the current and next presented instruction.
- fetch_instr  out  DATA_W  registered instruction.
- fetch_valid  out  1  fetch_instr is a real fetched word.
- fetch_misalign  out  1  registered flag: fetch_pc[1:0] != 0 on the accepted fetch.

Behaviour:
- Reset (async assert, sync release): state EMPTY; load_ready=0, load_busy=0, load_done=0, fetch_instr=NOP_WORD, fetch_valid=0, fetch_misalign=0; write pointer and remaining count = 0. Memory array is not reset.
- FSM EMPTY, LOAD, RUN.
  - EMPTY/RUN + load_start with load_count != 0 -> LOAD; capture wptr=load_base, remain=load_count.
  - load_start with load_count == 0: ignored, state unchanged.
  - load_start while in LOAD: ignored.
- LOAD:
  - load_ready=1 and load_busy=1 combinationally from state.
  - On load_valid&&load_ready: mem[wptr]<=load_data; wptr<=wptr+1 (wraps modulo 2**ADDR_W); remain<=remain-1.
  - On acceptance with remain==1: next state RUN; load_done=1 for exactly that next cycle.
  - load_valid without ready is held by the source; no data is lost.
- Fetch path (registered, latency 1). Priority per cycle: flush > stall > state/enable.
  - fetch_flush=1: next fetch_instr=NOP_WORD, fetch_valid=0, fetch_misalign=0, in every state.
  - fetch_stall=1 (no flush): all fetch outputs hold their values.
  - State != RUN: fetch_instr=NOP_WORD, fetch_valid=0, fetch_misalign=0.
  - RUN && fetch_en:
    - Aligned: fetch_instr<=mem[fetch_pc[ADDR_W+1:2]], fetch_valid<=1, fetch_misalign<=0.
    - Misaligned: fetch_instr<=NOP_WORD, fetch_valid<=0, fetch_misalign<=1.
  - RUN && !fetch_en: fetch_instr<=NOP_WORD, fetch_valid<=0, fetch_misalign<=0.
- Fetch reads and load writes never overlap, because fetch is blocked outside RUN; no read-during-write rule is needed.
- Reload from RUN is allowed. Fetch outputs go NOP from the cycle after load_start is accepted.
- Reset mid-load: returns to EMPTY. Partially written contents are retained but unusable until a complete burst finishes.
- Memory is inferable as single-port-write / single-port-read block RAM; no combinational path from fetch_pc to fetch_instr.

Test Plan:
- Reset then fetch_en=1, fetch_pc=0 for 5 cycles -> fetch_instr=32'h00000013, fetch_valid=0 every cycle.
- load_start, base=0, count=4; words 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233 sent back-to-back -> load_done pulses once, 1 cycle after the 4th accept. Then fetch_pc=0,4,8,12 -> same four words, each 1 cycle later, fetch_valid=1.
- Load base=1022, count=4, words A,B,C,D -> written at 1022, 1023, 0, 1 (wrap). Fetch_pc=4088 -> A; fetch_pc=4 -> D.
- RUN, fetch_pc=6 -> fetch_misalign=1, fetch_valid=0, fetch_instr=NOP.
- Stall for 3 cycles after fetching word at pc 8 -> output holds 32'h002081B3. Flush asserted together with stall -> NOP, valid=0 on the next cycle.
- Assert rst_n=0 after 2 of 4 load words -> immediate NOP/valid=0, state EMPTY. Fetch returns NOP until a new complete load finishes; load_start with count=0 in EMPTY stays EMPTY.
